// File: rtl/rggen_rtl_pkg.sv
// Shared bus types for the rggen register-bus responder.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  // Number of low address bits that select a byte within one data word.
  function automatic int rggen_byte_shift(int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/rggen_bus_if.sv
// Request/response bus between a register-bus master and a responder.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  import rggen_rtl_pkg::*;

  logic                      request;
  logic [ADDRESS_WIDTH-1:0]  address;
  rggen_direction            direction;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH/8-1:0]   write_strobe;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     read_data;
  rggen_status               status;

  modport master (
    output request, address, direction, write_data, write_strobe,
    input  ready, read_data, status
  );

  modport slave (
    input  request, address, direction, write_data, write_strobe,
    output ready, read_data, status
  );

endinterface

// File: rtl/rggen_bus_responder_storage.sv
// Word array with byte-strobed write port and combinational read port.
module rggen_bus_responder_storage #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    DEPTH         = 16,
  parameter int                    INDEX_WIDTH   = 4,
  parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_write_en,
  input  logic [INDEX_WIDTH-1:0]    i_index,
  input  logic [DATA_WIDTH-1:0]     i_write_data,
  input  logic [DATA_WIDTH/8-1:0]   i_write_strobe,
  output logic [DATA_WIDTH-1:0]     o_read_data
);

  localparam int STROBE_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] w_bit_mask;

  // Expand each strobe bit over its byte lane.
  generate
    for (genvar gi = 0; gi < STROBE_WIDTH; gi++) begin : g_lane
      assign w_bit_mask[8*gi +: 8] = {8{i_write_strobe[gi]}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= INITIAL_VALUE;
      end
    end else if (i_write_en) begin
      r_mem[i_index] <= (r_mem[i_index] & ~w_bit_mask) | (i_write_data & w_bit_mask);
    end
  end

  assign o_read_data = r_mem[i_index];

endmodule

// File: rtl/rggen_bus_responder.sv
// Register-bus responder: IDLE/WAIT/RESPOND handshake over a strobed word store.
// Define RGGEN_BUS_RESPONDER_STROBE_CHECK_EN to reject writes with an all-zero strobe.
module rggen_bus_responder
  import rggen_rtl_pkg::*;
#(
  parameter int                    ADDRESS_WIDTH = 8,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    DEPTH         = 16,
  parameter int                    WAIT_CYCLES   = 0,
  parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
)(
  input  logic        clk,
  input  logic        rst,
  rggen_bus_if.slave  bus_if,
  output logic        busy
);

  localparam int STROBE_WIDTH = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT   = rggen_byte_shift(DATA_WIDTH);
  localparam int INDEX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [1:0] state_t;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  state_t                    r_state;
  logic [3:0]                r_wait_count;
  logic [ADDRESS_WIDTH-1:0]  r_address;
  rggen_direction            r_direction;
  logic [DATA_WIDTH-1:0]     r_write_data;
  logic [STROBE_WIDTH-1:0]   r_write_strobe;

  logic [ADDRESS_WIDTH-1:0]  w_index;
  logic                      w_index_valid;
  logic                      w_ready;
  logic                      w_strobe_error;
  logic                      w_write_en;
  logic [DATA_WIDTH-1:0]     w_mem_read_data;
  rggen_status               w_status;

  // Requests are only sampled in IDLE; later phases work off the captured copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_wait_count   <= '0;
      r_address      <= '0;
      r_direction    <= RGGEN_READ;
      r_write_data   <= '0;
      r_write_strobe <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus_if.request) begin
            r_address      <= bus_if.address;
            r_direction    <= bus_if.direction;
            r_write_data   <= bus_if.write_data;
            r_write_strobe <= bus_if.write_strobe;
            r_wait_count   <= '0;
            r_state        <= (WAIT_CYCLES > 0) ? WAIT : RESPOND;
          end
        end
        WAIT: begin
          if (r_wait_count == 4'(WAIT_CYCLES - 1)) begin
            r_wait_count <= '0;
            r_state      <= RESPOND;
          end else begin
            r_wait_count <= r_wait_count + 4'd1;
          end
        end
        RESPOND: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_index       = r_address >> BYTE_SHIFT;
  assign w_index_valid = (32'(w_index) < 32'(DEPTH));
  assign w_ready       = (r_state == RESPOND);

`ifdef RGGEN_BUS_RESPONDER_STROBE_CHECK_EN
  assign w_strobe_error = (r_direction == RGGEN_WRITE) && (r_write_strobe == '0);
`else
  assign w_strobe_error = 1'b0;
`endif

  // The write lands on the edge that closes RESPOND, so a read sees the pre-write word.
  assign w_write_en = w_ready && (r_direction == RGGEN_WRITE) && w_index_valid && !w_strobe_error;

  rggen_bus_responder_storage #(
    .DATA_WIDTH    (DATA_WIDTH),
    .DEPTH         (DEPTH),
    .INDEX_WIDTH   (INDEX_WIDTH),
    .INITIAL_VALUE (INITIAL_VALUE)
  ) u_storage (
    .clk            (clk),
    .rst            (rst),
    .i_write_en     (w_write_en),
    .i_index        (w_index[INDEX_WIDTH-1:0]),
    .i_write_data   (r_write_data),
    .i_write_strobe (r_write_strobe),
    .o_read_data    (w_mem_read_data)
  );

  always_comb begin
    w_status = RGGEN_OKAY;
    if (w_ready) begin
      if (!w_index_valid) begin
        w_status = RGGEN_DECODE_ERROR;
      end else if (w_strobe_error) begin
        w_status = RGGEN_SLAVE_ERROR;
      end
    end
  end

  assign bus_if.ready     = w_ready;
  assign bus_if.status    = w_status;
  assign bus_if.read_data = (w_ready && (r_direction == RGGEN_READ) && w_index_valid)
                            ? w_mem_read_data : '0;
  assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_rggen_bus_responder.sv
// Directed bench for rggen_bus_responder with zero and three wait states.
module tb_rggen_bus_responder;
  import rggen_rtl_pkg::*;

  localparam logic [31:0] INIT3 = 32'h5A5A_0F0F;

`ifdef RGGEN_BUS_RESPONDER_STROBE_CHECK_EN
  localparam rggen_status EXP_ZERO_STROBE = RGGEN_SLAVE_ERROR;
`else
  localparam rggen_status EXP_ZERO_STROBE = RGGEN_OKAY;
`endif

  logic clk;
  logic rst;
  logic busy0;
  logic busy3;

  int n_vec;
  int n_err;

  int          t_lat;
  int          t_busy;
  logic [31:0] t_rdata;
  rggen_status t_status;

  rggen_bus_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) bus0 ();
  rggen_bus_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) bus3 ();

  rggen_bus_responder #(
    .ADDRESS_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(0), .INITIAL_VALUE(32'h0)
  ) dut0 (
    .clk(clk), .rst(rst), .bus_if(bus0), .busy(busy0)
  );

  rggen_bus_responder #(
    .ADDRESS_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(3), .INITIAL_VALUE(INIT3)
  ) dut3 (
    .clk(clk), .rst(rst), .bus_if(bus3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transfer on dut0 (sel=0) or dut3 (sel=1); live inputs are scrambled after capture.
  task automatic xfer(input int sel, input rggen_direction dir, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb);
    bit          done;
    logic        rdy;
    logic        bsy;
    logic [31:0] rd;
    rggen_status st;
    rggen_direction flip;
    done     = 1'b0;
    t_lat    = 0;
    t_busy   = 0;
    t_rdata  = 32'hXXXX_XXXX;
    t_status = RGGEN_SLAVE_ERROR;
    flip     = (dir == RGGEN_READ) ? RGGEN_WRITE : RGGEN_READ;
    @(negedge clk);
    if (sel == 0) begin
      bus0.request = 1'b1; bus0.address = addr; bus0.direction = dir;
      bus0.write_data = wdata; bus0.write_strobe = strb;
    end else begin
      bus3.request = 1'b1; bus3.address = addr; bus3.direction = dir;
      bus3.write_data = wdata; bus3.write_strobe = strb;
    end
    @(posedge clk);
    #1;
    if (sel == 0) begin
      bus0.address = addr ^ 8'h44; bus0.direction = flip;
      bus0.write_data = ~wdata; bus0.write_strobe = ~strb;
    end else begin
      bus3.address = addr ^ 8'h44; bus3.direction = flip;
      bus3.write_data = ~wdata; bus3.write_strobe = ~strb;
    end
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (sel == 0) begin
        rdy = bus0.ready; bsy = busy0; rd = bus0.read_data; st = bus0.status;
      end else begin
        rdy = bus3.ready; bsy = busy3; rd = bus3.read_data; st = bus3.status;
      end
      if (bsy) t_busy++;
      if (rdy) begin
        done = 1'b1; t_lat = k; t_rdata = rd; t_status = st;
      end
    end
    @(posedge clk);
    #1;
    if (sel == 0) bus0.request = 1'b0;
    else          bus3.request = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL xfer_timeout: dut%0d addr=%02h got no ready, want ready within 20 cycles", sel, addr);
    end
    $display("dut%0d %s addr=%02h wdata=%08h strb=%h -> lat=%0d busy=%0d rdata=%08h status=%s",
             sel == 0 ? 0 : 3, dir.name(), addr, wdata, strb, t_lat, t_busy, t_rdata, t_status.name());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (bus0.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready0: got %b want 0", bus0.ready); end
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy0: got %b want 0", busy0); end
    n_vec++; if (bus0.read_data !== 32'h0) begin n_err++; $display("FAIL reset_rdata0: got %08h want 00000000", bus0.read_data); end
    n_vec++; if (bus0.status !== RGGEN_OKAY) begin n_err++; $display("FAIL reset_status0: got %b want 00", bus0.status); end
    n_vec++; if (bus3.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready3: got %b want 0", bus3.ready); end
    n_vec++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL reset_busy3: got %b want 0", busy3); end
    n_vec++; if (bus3.read_data !== 32'h0) begin n_err++; $display("FAIL reset_rdata3: got %08h want 00000000", bus3.read_data); end
    n_vec++; if (bus3.status !== RGGEN_OKAY) begin n_err++; $display("FAIL reset_status3: got %b want 00", bus3.status); end
  endtask

  task automatic test_no_wait();
    xfer(0, RGGEN_WRITE, 8'h04, 32'hDEADBEEF, 4'hF);
    n_vec++; if (t_lat !== 1) begin n_err++; $display("FAIL w0_write_latency: got %0d want 1", t_lat); end
    n_vec++; if (t_status !== RGGEN_OKAY) begin n_err++; $display("FAIL w0_write_status: got %b want 00", t_status); end
    n_vec++; if (t_busy !== 1) begin n_err++; $display("FAIL w0_write_busy: got %0d want 1", t_busy); end
    @(negedge clk);
    n_vec++; if (bus0.ready !== 1'b0) begin n_err++; $display("FAIL w0_ready_single: got %b want 0", bus0.ready); end
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL w0_busy_after: got %b want 0", busy0); end
    xfer(0, RGGEN_READ, 8'h04, 32'h0, 4'h0);
    n_vec++; if (t_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL w0_read_data: got %08h want deadbeef", t_rdata); end
    n_vec++; if (t_status !== RGGEN_OKAY) begin n_err++; $display("FAIL w0_read_status: got %b want 00", t_status); end
    n_vec++; if (t_lat !== 1) begin n_err++; $display("FAIL w0_read_latency: got %0d want 1", t_lat); end
  endtask

  task automatic test_wait_states();
    xfer(1, RGGEN_READ, 8'h00, 32'h0, 4'h0);
    n_vec++; if (t_lat !== 4) begin n_err++; $display("FAIL w3_read_latency: got %0d want 4", t_lat); end
    n_vec++; if (t_busy !== 4) begin n_err++; $display("FAIL w3_read_busy: got %0d want 4", t_busy); end
    n_vec++; if (t_rdata !== INIT3) begin n_err++; $display("FAIL w3_read_init: got %08h want %08h", t_rdata, INIT3); end
    n_vec++; if (t_status !== RGGEN_OKAY) begin n_err++; $display("FAIL w3_read_status: got %b want 00", t_status); end
  endtask

  task automatic test_back_to_back();
    xfer(1, RGGEN_WRITE, 8'h14, 32'hCAFEF00D, 4'hF);
    n_vec++; if (t_lat !== 4) begin n_err++; $display("FAIL b2b_write_latency: got %0d want 4", t_lat); end
    xfer(1, RGGEN_READ, 8'h14, 32'h0, 4'h0);
    n_vec++; if (t_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_read_data: got %08h want cafef00d", t_rdata); end
    n_vec++; if (t_lat !== 4) begin n_err++; $display("FAIL b2b_read_latency: got %0d want 4", t_lat); end
  endtask

  task automatic test_byte_strobe();
    xfer(0, RGGEN_WRITE, 8'h08, 32'h11223344, 4'hF);
    xfer(0, RGGEN_WRITE, 8'h08, 32'hAABBCCDD, 4'b0101);
    xfer(0, RGGEN_READ, 8'h08, 32'h0, 4'h0);
    n_vec++; if (t_rdata !== 32'h11BB33DD) begin n_err++; $display("FAIL strobe_merge: got %08h want 11bb33dd", t_rdata); end
    xfer(0, RGGEN_READ, 8'h0B, 32'h0, 4'h0);
    n_vec++; if (t_rdata !== 32'h11BB33DD) begin n_err++; $display("FAIL strobe_low_addr_bits: got %08h want 11bb33dd", t_rdata); end
  endtask

  task automatic test_decode_error();
    xfer(0, RGGEN_READ, 8'h40, 32'h0, 4'h0);
    n_vec++; if (t_status !== RGGEN_DECODE_ERROR) begin n_err++; $display("FAIL decode_read_status: got %b want 11", t_status); end
    n_vec++; if (t_rdata !== 32'h0) begin n_err++; $display("FAIL decode_read_data: got %08h want 00000000", t_rdata); end
    xfer(0, RGGEN_WRITE, 8'h40, 32'hFFFFFFFF, 4'hF);
    n_vec++; if (t_status !== RGGEN_DECODE_ERROR) begin n_err++; $display("FAIL decode_write_status: got %b want 11", t_status); end
    xfer(0, RGGEN_READ, 8'h3C, 32'h0, 4'h0);
    n_vec++; if (t_status !== RGGEN_OKAY) begin n_err++; $display("FAIL last_word_status: got %b want 00", t_status); end
    n_vec++; if (t_rdata !== 32'h0) begin n_err++; $display("FAIL last_word_data: got %08h want 00000000", t_rdata); end
    xfer(0, RGGEN_READ, 8'h00, 32'h0, 4'h0);
    n_vec++; if (t_rdata !== 32'h0) begin n_err++; $display("FAIL decode_no_alias: got %08h want 00000000", t_rdata); end
    xfer(0, RGGEN_READ, 8'h04, 32'h0, 4'h0);
    n_vec++; if (t_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL decode_keep_04: got %08h want deadbeef", t_rdata); end
  endtask

  task automatic test_zero_strobe();
    xfer(0, RGGEN_WRITE, 8'h10, 32'h01020304, 4'hF);
    xfer(0, RGGEN_WRITE, 8'h10, 32'hFFFFFFFF, 4'h0);
    n_vec++; if (t_status !== EXP_ZERO_STROBE) begin n_err++; $display("FAIL zero_strobe_status: got %b want %b", t_status, EXP_ZERO_STROBE); end
    xfer(0, RGGEN_READ, 8'h10, 32'h0, 4'h0);
    n_vec++; if (t_rdata !== 32'h01020304) begin n_err++; $display("FAIL zero_strobe_data: got %08h want 01020304", t_rdata); end
  endtask

  task automatic test_reset_abort();
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus3.request = 1'b1; bus3.address = 8'h0C; bus3.direction = RGGEN_WRITE;
    bus3.write_data = 32'h12345678; bus3.write_strobe = 4'hF;
    @(negedge clk);
    n_vec++; if (busy3 !== 1'b1) begin n_err++; $display("FAIL abort_busy_in_wait: got %b want 1", busy3); end
    rst = 1'b1;
    bus3.request = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus3.ready) pulses++;
      if (i == 1) rst = 1'b0;
    end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL abort_no_ready: got %0d pulses want 0", pulses); end
    n_vec++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL abort_busy_after: got %b want 0", busy3); end
    xfer(1, RGGEN_READ, 8'h0C, 32'h0, 4'h0);
    n_vec++; if (t_rdata !== INIT3) begin n_err++; $display("FAIL abort_no_write: got %08h want %08h", t_rdata, INIT3); end
    xfer(1, RGGEN_READ, 8'h14, 32'h0, 4'h0);
    n_vec++; if (t_rdata !== INIT3) begin n_err++; $display("FAIL abort_reinit3: got %08h want %08h", t_rdata, INIT3); end
    xfer(0, RGGEN_READ, 8'h04, 32'h0, 4'h0);
    n_vec++; if (t_rdata !== 32'h0) begin n_err++; $display("FAIL abort_reinit0: got %08h want 00000000", t_rdata); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus0.request = 1'b0; bus0.address = '0; bus0.direction = RGGEN_READ;
    bus0.write_data = '0; bus0.write_strobe = '0;
    bus3.request = 1'b0; bus3.address = '0; bus3.direction = RGGEN_READ;
    bus3.write_data = '0; bus3.write_strobe = '0;
    test_reset();
    test_no_wait();
    test_wait_states();
    test_back_to_back();
    test_byte_strobe();
    test_decode_error();
    test_zero_strobe();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rggen_bus_responder.md
RGGEN_BUS_RESPONDER -- requirements
Module: rggen_bus_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8: byte-address width of bus_if.address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; a multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 16: number of DATA_WIDTH-bit words held.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0: wait states inserted before each response; range 0-15.
REQ-005 SHALL have parameter INITIAL_VALUE, default '0: reset value of every word.
REQ-006 SHALL have port clk  input  1  the single clock.
REQ-007 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-008 SHALL have port bus_if  rggen_bus_if.slave: it receives request, address, direction, write_data and write_strobe, and drives ready, read_data and status.
REQ-009 SHALL have port busy  output  1  high while a transfer is in WAIT or RESPOND.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT and RESPOND.
REQ-011 IDLE with request=1: SHALL capture address, direction, write_data and write_strobe; go to WAIT if WAIT_CYCLES>0, else to RESPOND.
REQ-012 WAIT: SHALL count WAIT_CYCLES cycles, then go to RESPOND.
REQ-013 RESPOND: SHALL drive ready=1 for exactly one cycle, then return to IDLE.
REQ-014 Latency: request first seen high at edge N -> ready=1 during cycle N+WAIT_CYCLES+1.
REQ-015 Request inputs SHALL be ignored outside IDLE; the captured copies are used.
REQ-016 Requester drops request on the edge that completes done; no request SHALL be accepted in the RESPOND cycle.
REQ-017 Word index = address >> $clog2(DATA_WIDTH/8); low address bits ignored.
REQ-018 Index >= DEPTH: status=RGGEN_DECODE_ERROR, read_data='0, storage unchanged.
REQ-019 Write to a valid index: storage SHALL update at the RESPOND edge, only bytes whose write_strobe bit=1; status=RGGEN_OKAY.
REQ-020 Read from a valid index: read_data = stored word at entry to RESPOND; status=RGGEN_OKAY.
REQ-021 read_data and status SHALL be '0 / RGGEN_OKAY whenever ready=0.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, ready=0, busy=0, read_data='0, status=RGGEN_OKAY, wait counter=0, all words=INITIAL_VALUE.
REQ-023 Reset during WAIT or RESPOND SHALL abort the transfer: no ready pulse and no storage write.

Configuration
REQ-024 With macro RGGEN_BUS_RESPONDER_STROBE_CHECK_EN defined: a write with write_strobe all-zero SHALL return status=RGGEN_SLAVE_ERROR and leave storage unchanged.
REQ-025 Without the macro: an all-zero-strobe write SHALL complete with RGGEN_OKAY and change nothing.
REQ-026 Without the macro, no checker logic SHALL be present.

Structure
REQ-027 rggen_rtl_pkg SHALL hold:
- rggen_direction {RGGEN_READ, RGGEN_WRITE}
- rggen_status with RGGEN_OKAY=2'b00, RGGEN_SLAVE_ERROR=2'b10, RGGEN_DECODE_ERROR=2'b11
REQ-028 The FSM state type SHALL be local to the module.
REQ-029 Sub-module rggen_bus_responder_storage SHALL hold the byte-strobed word array (write port plus combinational read); FSM and wait counter stay in the top module.

Verification
REQ-030 WAIT_CYCLES=0:
- write 0xDEADBEEF to 0x04, strobe 4'hF -> ready one cycle after request, OKAY
- read 0x04 -> 0xDEADBEEF
REQ-031 WAIT_CYCLES=3:
- read 0x00 -> ready exactly 4 cycles after request
- busy high for 4 cycles
- read_data=INITIAL_VALUE
REQ-032 Write 0x11223344 then 0xAABBCCDD with strobe 4'b0101 to 0x08 -> read 0x08 returns 0x11BB33DD.
REQ-033 DEPTH=16, read 0x40 -> DECODE_ERROR, read_data 0; write 0x40 -> no word changes.
REQ-034 Assert rst during WAIT of a write to 0x0C (WAIT_CYCLES=3) -> no ready pulse; read 0x0C returns INITIAL_VALUE.
REQ-035 Strobe 4'h0 write, both macro settings -> SLAVE_ERROR with RGGEN_BUS_RESPONDER_STROBE_CHECK_EN, OKAY without; storage unchanged in both.
